time_disp_scan: RTL and testbench

- Downstream display stage for the clock datapath.
- Consumes binary seconds, minutes and hours from the mod-60/mod-24 counter chain.
- Converts each field to two BCD digits and time-multiplexes six 7-segment digits in hh.mm.ss order.
- Inputs are snapshotted once per scan frame so a counter roll-over never tears the displayed time.

---
 rtl/time_disp_pkg.sv | 48 ++++
 rtl/time_disp_scan_bin2bcd60.sv | 36 +++
 rtl/time_disp_scan.sv | 152 +++++++++++++++
 tb/tb_time_disp_scan.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_disp_pkg.sv
// Shared constants for the hh.mm.ss multiplexed 7-segment display stage:
// digit slot indices, adjust-field codes and active-high segment patterns {g,f,e,d,c,b,a}.
package time_disp_pkg;

  typedef logic [6:0] seg_t;

  localparam logic [2:0] IDX_SEC_O  = 3'd0;
  localparam logic [2:0] IDX_SEC_T  = 3'd1;
  localparam logic [2:0] IDX_MIN_O  = 3'd2;
  localparam logic [2:0] IDX_MIN_T  = 3'd3;
  localparam logic [2:0] IDX_HOUR_O = 3'd4;
  localparam logic [2:0] IDX_HOUR_T = 3'd5;

  localparam logic [1:0] FLD_SEC  = 2'd0;
  localparam logic [1:0] FLD_MIN  = 2'd1;
  localparam logic [1:0] FLD_HOUR = 2'd2;
  localparam logic [1:0] FLD_NONE = 2'd3;

  localparam seg_t SEG_0    = 7'b0111111;
  localparam seg_t SEG_1    = 7'b0000110;
  localparam seg_t SEG_2    = 7'b1011011;
  localparam seg_t SEG_3    = 7'b1001111;
  localparam seg_t SEG_4    = 7'b1100110;
  localparam seg_t SEG_5    = 7'b1101101;
  localparam seg_t SEG_6    = 7'b1111101;
  localparam seg_t SEG_7    = 7'b0000111;
  localparam seg_t SEG_8    = 7'b1111111;
  localparam seg_t SEG_9    = 7'b1101111;
  localparam seg_t SEG_DASH = 7'b1000000;
  localparam seg_t SEG_OFF  = 7'b0000000;

  function automatic seg_t digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = SEG_0;
      4'd1:    digit_seg = SEG_1;
      4'd2:    digit_seg = SEG_2;
      4'd3:    digit_seg = SEG_3;
      4'd4:    digit_seg = SEG_4;
      4'd5:    digit_seg = SEG_5;
      4'd6:    digit_seg = SEG_6;
      4'd7:    digit_seg = SEG_7;
      4'd8:    digit_seg = SEG_8;
      4'd9:    digit_seg = SEG_9;
      default: digit_seg = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/time_disp_scan_bin2bcd60.sv
// Combinational 6-bit binary to two-digit BCD split with a 60/24 range flag.
module bin2bcd60 (
  input  logic [5:0] bin,
  input  logic       lim24,
  output logic [2:0] tens,
  output logic [3:0] ones,
  output logic       in_range
);

  logic [3:0] tens_x10_lo;

  always_comb begin
    if      (bin >= 6'd60) tens = 3'd6;
    else if (bin >= 6'd50) tens = 3'd5;
    else if (bin >= 6'd40) tens = 3'd4;
    else if (bin >= 6'd30) tens = 3'd3;
    else if (bin >= 6'd20) tens = 3'd2;
    else if (bin >= 6'd10) tens = 3'd1;
    else                   tens = 3'd0;

    // Low nibble of tens*10; the remainder is below 10 so modulo-16 subtraction is exact.
    case (tens)
      3'd1:    tens_x10_lo = 4'd10;
      3'd2:    tens_x10_lo = 4'd4;
      3'd3:    tens_x10_lo = 4'd14;
      3'd4:    tens_x10_lo = 4'd8;
      3'd5:    tens_x10_lo = 4'd2;
      3'd6:    tens_x10_lo = 4'd12;
      default: tens_x10_lo = 4'd0;
    endcase
  end

  assign ones     = bin[3:0] - tens_x10_lo;
  assign in_range = lim24 ? (bin < 6'd24) : (bin < 6'd60);

endmodule

// File: rtl/time_disp_scan.sv
// Six-digit hh.mm.ss 7-segment scanner with per-frame input snapshot and dash on out-of-range fields.
// Optional adjust-field blinking is built when TIME_DISP_BLINK_EN is defined.
module time_disp_scan
  import time_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       adjust,
  input  logic [1:0] adj_field,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_p0;
  logic [2:0]       idx_p0;
  logic [5:0]       sec_sh_p0;
  logic [5:0]       min_sh_p0;
  logic [4:0]       hour_sh_p0;
  logic             slot_end;
  logic             frame_end;

  assign slot_end  = (cnt_p0 == CNT_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx_p0 == IDX_HOUR_T);

  // Stage p0: prescaler, digit index and frame-wrap snapshot
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt_p0     <= '0;
      idx_p0     <= IDX_SEC_O;
      sec_sh_p0  <= '0;
      min_sh_p0  <= '0;
      hour_sh_p0 <= '0;
    end else if (slot_end) begin
      cnt_p0 <= '0;
      if (frame_end) begin
        idx_p0     <= IDX_SEC_O;
        sec_sh_p0  <= sec;
        min_sh_p0  <= min;
        hour_sh_p0 <= hour;
      end else begin
        idx_p0 <= idx_p0 + 3'd1;
      end
    end else begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  logic       blank_p0;
`ifdef TIME_DISP_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FC_W-1:0] fcnt_p0;
  logic            blink_phase_p0;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      fcnt_p0        <= '0;
      blink_phase_p0 <= 1'b0;
    end else if (frame_end) begin
      if (fcnt_p0 == FC_W'(BLINK_FRAMES - 1)) begin
        fcnt_p0        <= '0;
        blink_phase_p0 <= ~blink_phase_p0;
      end else begin
        fcnt_p0 <= fcnt_p0 + 1'b1;
      end
    end
  end

  assign blank_p0 = adjust && blink_phase_p0 && (adj_field != FLD_NONE) &&
                    (idx_p0[2:1] == adj_field);
`else
  logic unused_adjust;
  assign unused_adjust = ^{adjust, adj_field};
  assign blank_p0      = 1'b0;
`endif

  logic [5:0] field_bin;
  logic       field_lim24;
  logic [2:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       bcd_in_range;

  always_comb begin
    field_bin   = sec_sh_p0;
    field_lim24 = 1'b0;
    case (idx_p0[2:1])
      FLD_SEC:  field_bin = sec_sh_p0;
      FLD_MIN:  field_bin = min_sh_p0;
      default: begin
        field_bin   = {1'b0, hour_sh_p0};
        field_lim24 = 1'b1;
      end
    endcase
  end

  bin2bcd60 u_bcd (
    .bin      (field_bin),
    .lim24    (field_lim24),
    .tens     (bcd_tens),
    .ones     (bcd_ones),
    .in_range (bcd_in_range)
  );

  logic [5:0] an_nxt;
  seg_t       seg_nxt;
  logic       dp_nxt;

  always_comb begin
    an_nxt = 6'b000001 << idx_p0;
    if (cnt_p0 == '0 || blank_p0) an_nxt = '0;
    if (!bcd_in_range)   seg_nxt = SEG_DASH;
    else if (idx_p0[0])  seg_nxt = digit_seg({1'b0, bcd_tens});
    else                 seg_nxt = digit_seg(bcd_ones);
    dp_nxt = (idx_p0 == IDX_MIN_O) || (idx_p0 == IDX_HOUR_O);
  end

  logic [5:0] an_p1;
  logic [6:0] seg_p1;
  logic       dp_p1;
  logic       frame_p1;

  // Stage p1: registered, polarity-adjusted drive to the display
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      an_p1    <= {6{SEG_ACTIVE_LOW}};
      seg_p1   <= {7{SEG_ACTIVE_LOW}};
      dp_p1    <= SEG_ACTIVE_LOW;
      frame_p1 <= 1'b0;
    end else begin
      an_p1    <= an_nxt ^ {6{SEG_ACTIVE_LOW}};
      seg_p1   <= seg_nxt ^ {7{SEG_ACTIVE_LOW}};
      dp_p1    <= dp_nxt ^ SEG_ACTIVE_LOW;
      frame_p1 <= frame_end;
    end
  end

  assign an    = an_p1;
  assign seg   = seg_p1;
  assign dp    = dp_p1;
  assign frame = frame_p1;

endmodule

// File: tb/tb_time_disp_scan.sv
// Self-checking bench for time_disp_scan: position-based reference model plus literal spot checks.
`timescale 1ns/1ps
module tb_time_disp_scan;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_CYC    = SCAN_DIV * 6;

  logic       clk = 1'b0;
  logic       clear;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [4:0] hour = '0;
  logic       adjust = 1'b0;
  logic [1:0] adj_field = 2'd3;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  time_disp_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .BLINK_FRAMES   (BLINK_FRAMES),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .adjust    (adjust),
    .adj_field (adj_field),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame     (frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  localparam logic [6:0] DASH = 7'b1000000;

  // model state
  int steps = 0;
  int p_cur = -1;
  int sh_sec = 0, sh_min = 0, sh_hour = 0;
  logic [5:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_frame;
  int last_frame_cyc = -1;
  logic [6:0] obs_seg [6];
  logic       obs_dp [6];
  bit         lit23 [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] digit_code(input int val, input int lim, input bit tens);
    if (val >= lim) return DASH;
    return tens ? seg_tab[val / 10] : seg_tab[val % 10];
  endfunction

  // Reference model: each output is a function of position since release and the frame snapshot.
  always @(posedge clk) begin
    int p, c, idx, f, val;
    cyc++;
    if (clear) begin
      steps = 0; p_cur = -1;
      sh_sec = 0; sh_min = 0; sh_hour = 0;
      e_an = '0; e_seg = '0; e_dp = 1'b0; e_frame = 1'b0;
      last_frame_cyc = -1;
      for (int i = 0; i < 16; i++) lit23[i] = 1'b0;
    end else begin
      p = steps; steps++; p_cur = p;
      c = p % SCAN_DIV;
      idx = (p / SCAN_DIV) % 6;
      f = p / FRAME_CYC;
      e_an = (c == 0) ? 6'd0 : 6'(1 << idx);
`ifdef TIME_DISP_BLINK_EN
      if (adjust && ((f / BLINK_FRAMES) % 2 == 1) && adj_field != 2'd3 && int'(adj_field) == idx / 2)
        e_an = '0;
`endif
      case (idx / 2)
        0:       val = sh_sec;
        1:       val = sh_min;
        default: val = sh_hour;
      endcase
      e_seg   = digit_code(val, (idx / 2 == 2) ? 24 : 60, (idx % 2) == 1);
      e_dp    = (idx == 2 || idx == 4);
      e_frame = (p % FRAME_CYC) == FRAME_CYC - 1;
      if (e_frame) begin
        sh_sec = int'(sec); sh_min = int'(min); sh_hour = int'(hour);
      end
    end
    #1;
    chk("an", int'(an), int'(e_an));
    chk("seg", int'(seg), int'(e_seg));
    chk("dp", int'(dp), int'(e_dp));
    chk("frame", int'(frame), int'(e_frame));
    if (!clear && p_cur >= 0) begin
      for (int i = 0; i < 6; i++)
        if (an[i]) begin obs_seg[i] = seg; obs_dp[i] = dp; end
      if ((an[2] || an[3]) && (p_cur / FRAME_CYC) < 16) lit23[p_cur / FRAME_CYC] = 1'b1;
      if (frame) begin
        if (last_frame_cyc >= 0) chk("frame_period", cyc - last_frame_cyc, FRAME_CYC);
        last_frame_cyc = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart(input int hold);
    @(negedge clk);
    clear = 1'b1;
    step(hold);
    clear = 1'b0;
  endtask

  task automatic blink_run(input logic [1:0] fld, input bit blink_expected);
    bit exp_lit;
    adjust = 1'b1; adj_field = fld;
    restart(2);
    step(6 * FRAME_CYC);
    for (int f = 0; f < 6; f++) begin
      exp_lit = !(blink_expected && (f == 2 || f == 3));
      chk($sformatf("blink_lit_f%0d", f), int'(lit23[f]), int'(exp_lit));
    end
    adjust = 1'b0; adj_field = 2'd3;
  endtask

  initial begin
    bit blink_on;
`ifdef TIME_DISP_BLINK_EN
    blink_on = 1'b1;
`else
    blink_on = 1'b0;
`endif
    clear = 1'b1;
    step(3);
    chk("reset_an", int'(an), 0);
    chk("reset_seg", int'(seg), 0);
    chk("reset_frame", int'(frame), 0);

    // Nominal display 23.05.37, visible from the second frame
    hour = 5'd23; min = 6'd5; sec = 6'd37;
    clear = 1'b0;
    step(1);
    chk("rel_gap_an", int'(an), 0);
    step(1);
    chk("rel_idx0_an", int'(an), 6'b000001);
    chk("rel_idx0_seg", int'(seg), 7'b0111111);
    step(2 * FRAME_CYC - 2);
    chk("nom_seg0", int'(obs_seg[0]), 7'b0000111);
    chk("nom_seg1", int'(obs_seg[1]), 7'b1001111);
    chk("nom_seg2", int'(obs_seg[2]), 7'b1101101);
    chk("nom_seg3", int'(obs_seg[3]), 7'b0111111);
    chk("nom_seg4", int'(obs_seg[4]), 7'b1001111);
    chk("nom_seg5", int'(obs_seg[5]), 7'b1011011);
    for (int i = 0; i < 6; i++)
      chk($sformatf("nom_dp%0d", i), int'(obs_dp[i]), (i == 2 || i == 4) ? 1 : 0);

    // Snapshot: change sec during idx3 of the third frame
    step(3 * SCAN_DIV + 2);
    sec = 6'd38;
    step(FRAME_CYC - 3 * SCAN_DIV - 2);
    chk("snap_same_frame", int'(obs_seg[0]), 7'b0000111);
    step(FRAME_CYC);
    chk("snap_next_frame", int'(obs_seg[0]), 7'b1111111);

    // Out-of-range hour and minute
    hour = 5'd25; min = 6'd60;
    step(2 * FRAME_CYC);
    for (int i = 2; i < 6; i++) chk($sformatf("oor_seg%0d", i), int'(obs_seg[i]), DASH);
    chk("oor_seg0", int'(obs_seg[0]), 7'b1111111);
    chk("oor_seg1", int'(obs_seg[1]), 7'b1001111);

    // Blinking of the minute field, then no blanking for field code 3
    blink_run(2'd1, blink_on);
    blink_run(2'd3, 1'b0);

    // Randomized inputs with occasional mid-slot clear
    for (int r = 0; r < 3000; r++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        sec  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
        min  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
        hour = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      end
      if ($urandom_range(0, 31) == 0) adjust = 1'($urandom);
      if ($urandom_range(0, 63) == 0) adj_field = 2'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #2;
        clear = 1'b1;
        #1;
        chk("async_clr_an", int'(an), 0);
        chk("async_clr_seg", int'(seg), 0);
        chk("async_clr_dp", int'(dp), 0);
        chk("async_clr_frame", int'(frame), 0);
        step(2);
        clear = 1'b0;
      end
    end

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
